// File: rtl/alu_share_arbiter.sv
// Two-port valid/ready front end that time-shares one combinational ALU.
// Operands and results are registered, so the ALU sits between two flop stages.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [2:0]            req0_op,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_result,
  output logic [2:0]            resp0_flags,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [2:0]            req1_op,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_result,
  output logic [2:0]            resp1_flags,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  alu_carryout,
  input  logic                  alu_zero,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic                  grant;
  logic                  grant_nx;
  logic                  last_grant;
  logic                  accept;
  logic                  resp_done;
  logic [DATA_WIDTH-1:0] result_q;
  logic [2:0]            flags_q;

  // One shared result register feeds both response ports; only the granted valid rises.
  assign resp0_result = result_q;
  assign resp1_result = result_q;
  assign resp0_flags  = flags_q;
  assign resp1_flags  = flags_q;

  // Next state, round-robin pick and the combinational request ready.
  always_comb begin
    state_nx   = state;
    grant_nx   = 1'b0;
    accept     = 1'b0;
    resp_done  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) grant_nx = ~last_grant;
        else                          grant_nx = req1_valid;
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_nx;
          req1_ready = grant_nx;
          state_nx   = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        resp_done = grant ? resp1_ready : resp0_ready;
        if (resp_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, operand, result and handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_op      <= 3'd0;
      result_q    <= '0;
      flags_q     <= 3'd0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      if (accept) begin
        grant  <= grant_nx;
        alu_A  <= grant_nx ? req1_A  : req0_A;
        alu_B  <= grant_nx ? req1_B  : req0_B;
        alu_op <= grant_nx ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        result_q    <= alu_result;
        flags_q     <= {alu_overflow, alu_carryout, alu_zero};
        resp0_valid <= ~grant;
        resp1_valid <= grant;
      end
      if (resp_done) begin
        resp0_valid <= 1'b0;
        resp1_valid <= 1'b0;
        last_grant  <= grant;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level round-robin model and a behavioural ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic [31:0] req0_A, req0_B, resp0_result;
  logic [2:0]  req0_op, resp0_flags;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [31:0] req1_A, req1_B, resp1_result;
  logic [2:0]  req1_op, resp1_flags;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [2:0]  alu_op;
  logic        alu_overflow, alu_carryout, alu_zero;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic lg_m;

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_flags(resp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_flags(resp1_flags),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_result(alu_result),
    .alu_overflow(alu_overflow), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {result, overflow, carryout, zero}.
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        ov, c;
    s = '0; r = '0; ov = 1'b0; c = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd3: r = a ^ b;
      3'd4: r = ~(a | b);
      3'd5: r = a >> b[4:0];
      3'd6: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = {31'd0, ($signed(a) < $signed(b))};
    endcase
    return {r, ov, c, (r == 32'd0)};
  endfunction

  always_comb {alu_result, alu_overflow, alu_carryout, alu_zero} = alu_f(alu_A, alu_B, alu_op);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; the winner is predicted from the round-robin rule.
  task automatic do_op(input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] o0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] o1,
                       input int stall, output logic w, output logic [31:0] res,
                       output logic [2:0] flg, output int acc);
    logic [34:0] e;
    logic [31:0] ea, eb;
    logic [2:0]  eo;
    req0_valid = v0; req0_A = a0; req0_B = b0; req0_op = o0;
    req1_valid = v1; req1_A = a1; req1_B = b1; req1_op = o1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    w  = (v0 && v1) ? ~lg_m : v1;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    eo = w ? o1 : o0;
    e  = alu_f(ea, eb, eo);
    chk("idle_req0_ready", 64'(req0_ready), 64'(!w));
    chk("idle_req1_ready", 64'(req1_ready), 64'(w));
    @(posedge clk); #1;
    acc = cyc;
    chk("exec_alu_A", 64'(alu_A), 64'(ea));
    chk("exec_alu_B", 64'(alu_B), 64'(eb));
    chk("exec_alu_op", 64'(alu_op), 64'(eo));
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_resp_valid", 64'({resp0_valid, resp1_valid}), 64'd0);
    chk("exec_ready", 64'({req0_ready, req1_ready}), 64'd0);
    // Early ready on the winner when no stall; the loser's ready is always high and must be ignored.
    resp0_ready = w ? 1'b1 : (stall == 0);
    resp1_ready = w ? (stall == 0) : 1'b1;
    @(posedge clk); #1;
    res = w ? resp1_result : resp0_result;
    flg = w ? resp1_flags : resp0_flags;
    chk("resp_valid", 64'({resp0_valid, resp1_valid}), w ? 64'd1 : 64'd2);
    chk("resp_result", 64'(res), 64'(e[34:3]));
    chk("resp_flags", 64'(flg), 64'(e[2:0]));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'({resp0_valid, resp1_valid}), w ? 64'd1 : 64'd2);
      chk("stall_result", 64'(w ? resp1_result : resp0_result), 64'(e[34:3]));
      chk("stall_flags", 64'(w ? resp1_flags : resp0_flags), 64'(e[2:0]));
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_ready", 64'({req0_ready, req1_ready}), 64'd0);
    end
    if (w) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_valid", 64'({resp0_valid, resp1_valid}), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    lg_m = w;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        w;
    logic [31:0] res;
    logic [2:0]  flg;
    int          acc, prev;
    logic        v0, v1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_op = '0; resp0_ready = 1'b0;
    req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_op = '0; resp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'({resp0_valid, resp1_valid}), 64'd0);
    chk("rst_alu_A", 64'(alu_A), 64'd0);
    chk("rst_alu_B", 64'(alu_B), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_result", 64'(resp0_result), 64'd0);
    chk("rst_flags", 64'(resp1_flags), 64'd0);
    rst_n = 1'b1;
    lg_m  = 1'b1;
    @(posedge clk); #1;

    // Simultaneous first requests: port 0 sub, then port 1 slt.
    do_op(1, 1, 32'd5, 32'd5, 3'b110, 32'd3, 32'd7, 3'b111, 0, w, res, flg, acc);
    chk("tie_first_port", 64'(w), 64'd0);
    chk("sub_result", 64'(res), 64'd0);
    chk("sub_zero", 64'(flg[0]), 64'd1);
    do_op(1, 1, 32'd5, 32'd5, 3'b110, 32'd3, 32'd7, 3'b111, 0, w, res, flg, acc);
    chk("tie_second_port", 64'(w), 64'd1);
    chk("slt_result", 64'(res), 64'd1);

    // Continuous contention: strict alternation, one op per 3 cycles.
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      do_op(1, 1, $urandom, $urandom, 3'($urandom), $urandom, $urandom, 3'($urandom),
            0, w, res, flg, acc);
      chk("contend_grant", 64'(w), 64'(k % 2));
      if (k > 0) chk("contend_spacing", 64'(acc - prev), 64'd3);
      prev = acc;
    end

    // Single add on port 0 with signed overflow.
    do_op(1, 0, 32'h7FFF_FFFF, 32'd1, 3'b010, 32'd0, 32'd0, 3'b000, 0, w, res, flg, acc);
    chk("add_port", 64'(w), 64'd0);
    chk("add_result", 64'(res), 64'h8000_0000);
    chk("add_flags", 64'(flg), 64'b100);

    // Response backpressure on port 1 with port 0's resp_ready held high.
    do_op(0, 1, 32'd0, 32'd0, 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b011, 4, w, res, flg, acc);
    chk("stall_port", 64'(w), 64'd1);
    chk("stall_spacing_xor", 64'(res), 64'hFF00_EDCB);

    // Reset while in EXEC.
    req0_valid = 1'b1; req0_A = 32'h1234; req0_B = 32'h55; req0_op = 3'd1;
    req1_valid = 1'b1; req1_A = 32'h9; req1_B = 32'h8; req1_op = 3'd2;
    @(posedge clk); #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lg_m = 1'b1;
    chk("exec_rst_busy", 64'(busy), 64'd0);
    chk("exec_rst_valid", 64'({resp0_valid, resp1_valid}), 64'd0);
    chk("exec_rst_alu", 64'({alu_A, alu_B} | 64'(alu_op)), 64'd0);
    chk("exec_rst_ready", 64'({req0_ready, req1_ready}), 64'd2);
    do_op(1, 1, 32'd10, 32'd4, 3'b110, 32'd1, 32'd2, 3'b000, 0, w, res, flg, acc);
    chk("post_rst_tie", 64'(w), 64'd0);
    chk("post_rst_result", 64'(res), 64'd6);

    // Randomized traffic with idle gaps, dropped requests and random stalls.
    for (int k = 0; k < 40; k++) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        #1;
        chk("gap_ready", 64'({req0_ready, req1_ready}), 64'd0);
        @(posedge clk); #1;
        chk("gap_busy", 64'(busy), 64'd0);
      end
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      do_op(v0, v1, $urandom, 32'($urandom_range(0, 40)), 3'($urandom),
            $urandom, $urandom, 3'($urandom), int'($urandom_range(0, 3)), w, res, flg, acc);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
